// File: rtl/pwm_decoder.sv
// ---------------------------------------------------------------------------
// pwm_decoder
//
// Recovers an 8-bit duty sample from a single-bit PWM waveform by counting
// the clk cycles the line is high between consecutive rising edges. Also
// reports the length of the last completed period and flags a stuck line
// when no rising edge arrives within TIMEOUT cycles.
//
// Optional feature (compile-time macro PWM_DEC_AVG_EN):
//   When defined, each normal sample is averaged with the previous one.
//   The first normal sample after idle, and every timeout sample, is raw.
//
// Parameters:
//   PERIOD   nominal PWM period in clk cycles (sanity-checked only)
//   TIMEOUT  cycles without a rising edge before the line is declared stuck
//   CW       counter width, derived from TIMEOUT; do not override
//
// Ports:
//   clk           system clock
//   n_rst         asynchronous active-low reset
//   pwm_in        PWM waveform, asynchronous to clk
//   sample_out    recovered duty sample, registered
//   sample_valid  one-cycle pulse when sample_out updates
//   period_out    measured period of the last completed cycle
//   stuck         high after a timeout, cleared on the next rising edge
// ---------------------------------------------------------------------------
module pwm_decoder #(
    parameter int unsigned PERIOD  = 256,
    parameter int unsigned TIMEOUT = 512,
    parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          pwm_in,
    output logic [7:0]    sample_out,
    output logic          sample_valid,
    output logic [CW-1:0] period_out,
    output logic          stuck
);

    // Elaboration-time parameter sanity checks.
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("pwm_decoder: TIMEOUT must be greater than 1");
    end
    if (PERIOD > TIMEOUT) begin : g_bad_period
        $error("pwm_decoder: PERIOD longer than TIMEOUT always times out");
    end

    localparam logic [CW-1:0] TimeoutCnt = CW'(TIMEOUT);
    localparam logic [CW-1:0] OneCnt     = CW'(1);

    typedef enum logic [0:0] {StIdle, StMeasure} state_e;

    state_e        state_q, state_d;
    logic          s1_q, pwm_s_q, pwm_d_q;
    logic          rise;
    logic [CW-1:0] period_cnt_q, period_cnt_d;
    logic [CW-1:0] high_cnt_q, high_cnt_d;
    logic [7:0]    sample_q, sample_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] period_q, period_d;
    logic          stuck_q, stuck_d;
    logic          timeout;
    logic [7:0]    raw_sample;
    logic [7:0]    norm_sample;

`ifdef PWM_DEC_AVG_EN
    logic [7:0] hist_q, hist_d;
    logic       first_q, first_d;
    logic [8:0] avg_sum;
`endif

    assign rise    = pwm_s_q & ~pwm_d_q;
    assign timeout = (state_q == StMeasure) && !rise && (period_cnt_q == TimeoutCnt);

    // Saturate at full scale when the high time exceeds 255 cycles.
    assign raw_sample = (32'(high_cnt_q) > 32'd255) ? 8'hFF : 8'(high_cnt_q);

`ifdef PWM_DEC_AVG_EN
    assign avg_sum     = {1'b0, hist_q} + {1'b0, raw_sample};
    assign norm_sample = first_q ? raw_sample : avg_sum[8:1];
`else
    assign norm_sample = raw_sample;
`endif

    // -----------------------------------------------------------------------
    // State register and input conditioning
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= StIdle;
            s1_q         <= 1'b0;
            pwm_s_q      <= 1'b0;
            pwm_d_q      <= 1'b0;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            sample_q     <= 8'h00;
            valid_q      <= 1'b0;
            period_q     <= '0;
            stuck_q      <= 1'b0;
`ifdef PWM_DEC_AVG_EN
            hist_q       <= 8'h00;
            first_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            s1_q         <= pwm_in;
            pwm_s_q      <= s1_q;
            pwm_d_q      <= pwm_s_q;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            sample_q     <= sample_d;
            valid_q      <= valid_d;
            period_q     <= period_d;
            stuck_q      <= stuck_d;
`ifdef PWM_DEC_AVG_EN
            hist_q       <= hist_d;
            first_q      <= first_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (rise) state_d = StMeasure;
            StMeasure: if (timeout) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // -----------------------------------------------------------------------
    // Counters and registered outputs
    // -----------------------------------------------------------------------
    always_comb begin
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        sample_d     = sample_q;
        valid_d      = 1'b0;
        period_d     = period_q;
        stuck_d      = stuck_q;
`ifdef PWM_DEC_AVG_EN
        hist_d       = hist_q;
        first_d      = first_q;
`endif
        unique case (state_q)
            StIdle: begin
                period_cnt_d = '0;
                high_cnt_d   = '0;
                if (rise) begin
                    // First edge only opens a measurement window.
                    period_cnt_d = OneCnt;
                    high_cnt_d   = OneCnt;
                    stuck_d      = 1'b0;
`ifdef PWM_DEC_AVG_EN
                    first_d      = 1'b1;
`endif
                end
            end
            StMeasure: begin
                if (rise) begin
                    // A rise on the timeout cycle still closes a normal period.
                    sample_d     = norm_sample;
                    period_d     = period_cnt_q;
                    valid_d      = 1'b1;
                    stuck_d      = 1'b0;
                    period_cnt_d = OneCnt;
                    high_cnt_d   = OneCnt;
`ifdef PWM_DEC_AVG_EN
                    hist_d       = raw_sample;
                    first_d      = 1'b0;
`endif
                end else if (timeout) begin
                    sample_d     = pwm_s_q ? 8'hFF : 8'h00;
                    valid_d      = 1'b1;
                    stuck_d      = 1'b1;
                    period_cnt_d = '0;
                    high_cnt_d   = '0;
`ifdef PWM_DEC_AVG_EN
                    hist_d       = pwm_s_q ? 8'hFF : 8'h00;
                    first_d      = 1'b1;
`endif
                end else begin
                    period_cnt_d = period_cnt_q + OneCnt;
                    high_cnt_d   = high_cnt_q + CW'(pwm_s_q);
                end
            end
            default: ;
        endcase
    end

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign period_out   = period_q;
    assign stuck        = stuck_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// ---------------------------------------------------------------------------
// tb_pwm_decoder
//
// Drives the decoder with PWM periods described as (high cycles, period
// cycles). A reference model predicts, per period, what sample the decoder
// must emit and pushes it to a queue; a monitor pops an entry on every
// sample_valid pulse and compares. Build with +define+PWM_DEC_AVG_EN to
// exercise the averaging variant.
// ---------------------------------------------------------------------------
module tb_pwm_decoder;

    localparam int unsigned TIMEOUT = 512;
    localparam int unsigned CW      = $clog2(TIMEOUT + 1);

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          pwm_in = 1'b0;
    logic [7:0]    sample_out;
    logic          sample_valid;
    logic [CW-1:0] period_out;
    logic          stuck;

    always #5 clk = ~clk;

    pwm_decoder #(
        .PERIOD  (256),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .pwm_in       (pwm_in),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .period_out   (period_out),
        .stuck        (stuck)
    );

    typedef struct packed {
        logic [7:0]    sample;
        logic [CW-1:0] period;
        logic          stuck;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state, in terms of whole PWM periods.
    bit measuring   = 1'b0;
    int cur_h       = 0;
    int cur_p       = 0;
    int last_period = 0;
    int last_sample = 0;
    bit exp_stuck   = 1'b0;
    int hist        = 0;
    bit first       = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // A period with h high cycles out of p completes: predict its sample.
    task automatic model_normal(input int h, input int p);
        int   nw;
        int   res;
        exp_t e;
        nw = (h > 255) ? 255 : h;
`ifdef PWM_DEC_AVG_EN
        res = first ? nw : (hist + nw) / 2;
`else
        res = nw;
`endif
        hist        = nw;
        first       = 1'b0;
        last_period = p;
        last_sample = res;
        e.sample    = 8'(res);
        e.period    = CW'(p);
        e.stuck     = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        check("queue_empty_at_reset", exp_q.size(), 0);
        exp_q.delete();
        measuring   = 1'b0;
        last_period = 0;
        last_sample = 0;
        exp_stuck   = 1'b0;
        hist        = 0;
        first       = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sample_out"}, int'(sample_out), 0);
        check({tag, "_sample_valid"}, int'(sample_valid), 0);
        check({tag, "_period_out"}, int'(period_out), 0);
        check({tag, "_stuck"}, int'(stuck), 0);
    endtask

    // One PWM period: rise, h cycles high, p-h cycles low (0 < h < p).
    // rst_at >= 0 pulses n_rst low for one cycle at that cycle index.
    task automatic run_seg(input int h, input int p, input int rst_at);
        exp_t e;
        if (measuring) model_normal(cur_h, cur_p);
        else first = 1'b1;
        measuring = 1'b1;
        cur_h     = h;
        cur_p     = p;
        exp_stuck = 1'b0;
        if (p > int'(TIMEOUT) && rst_at < 0) begin
            // No rise within TIMEOUT cycles: line level at that cycle is reported.
            e.sample    = (h > int'(TIMEOUT)) ? 8'hFF : 8'h00;
            e.period    = CW'(last_period);
            e.stuck     = 1'b1;
            exp_q.push_back(e);
            last_sample = int'(e.sample);
            hist        = int'(e.sample);
            exp_stuck   = 1'b1;
            measuring   = 1'b0;
        end
        for (int i = 0; i < p; i++) begin
            pwm_in = (i < h);
            if (i == rst_at) begin
                n_rst = 1'b0;
                #1;
                check_zero("async_reset");
                model_reset();
            end else if (rst_at >= 0 && i == rst_at + 1) begin
                n_rst = 1'b1;
            end
            @(negedge clk);
        end
        check("hold_stuck", int'(stuck), int'(exp_stuck));
        check("hold_sample_out", int'(sample_out), last_sample);
        check("hold_period_out", int'(period_out), last_period);
    endtask

    // Monitor: every valid pulse must match the oldest predicted sample.
    always begin
        @(posedge clk);
        #1;
        if (sample_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got sample_out=%0d period_out=%0d stuck=%0d, expected no pulse",
                         sample_out, period_out, stuck);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sample_out", int'(sample_out), int'(e.sample));
                check("period_out", int'(period_out), int'(e.period));
                check("stuck", int'(stuck), int'(e.stuck));
            end
        end
    end

    initial begin
        n_rst  = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        n_rst = 1'b1;

        // Idle low line: nothing must come out.
        repeat (1000) @(negedge clk);
        check_zero("idle");

        // Steady 25% duty.
        repeat (4) run_seg(64, 256, -1);

        // Near full scale, then saturation on a long period.
        run_seg(255, 256, -1);
        run_seg(300, 400, -1);
        run_seg(64, 256, -1);

        // Stuck high, recovery, then a normal sample.
        run_seg(600, 601, -1);
        run_seg(50, 256, -1);
        run_seg(64, 256, -1);

        // Stuck low.
        run_seg(10, 700, -1);
        run_seg(80, 256, -1);

        // Period exactly at the timeout: the rise wins.
        run_seg(100, 512, -1);
        run_seg(64, 256, -1);

        // Reset on the last high cycle; then averaging sequence from idle.
        run_seg(100, 256, 99);
        run_seg(64, 256, -1);
        run_seg(128, 256, -1);
        run_seg(128, 256, -1);
        run_seg(40, 256, -1);

        // Randomized periods.
        for (int k = 0; k < 30; k++) begin
            int p;
            int h;
            p = int'($urandom_range(500, 8));
            h = int'($urandom_range(p - 1, 1));
            run_seg(h, p, -1);
        end

        run_seg(50, 100, -1);
        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
